// File: rtl/alu_status_stage_if.sv
// Bus between the ALU/decoder (master) and the status stage (slave).
interface alu_status_stage_if;
  logic [7:0] alu_out;
  logic       alu_carry;
  logic       alu_half_carry;
  logic       alu_overflow;
  logic       op_valid;
  logic       is_adc;
  logic       is_sbc;
  logic       upd_nz;
  logic       upd_c;
  logic       upd_v;
  logic       upd_bit;
  logic [1:0] bit_operand;
  logic       p_load;
  logic [7:0] p_in;
  logic       flag_wr;
  logic [2:0] flag_sel;
  logic       flag_val;
  logic [7:0] result;
  logic       result_valid;
  logic       busy;
  logic [7:0] p_out;
  logic       c_flag;
  logic       dec_add;

  modport master (
    output alu_out, alu_carry, alu_half_carry, alu_overflow, op_valid,
           is_adc, is_sbc, upd_nz, upd_c, upd_v, upd_bit, bit_operand,
           p_load, p_in, flag_wr, flag_sel, flag_val,
    input  result, result_valid, busy, p_out, c_flag, dec_add
  );

  modport slave (
    input  alu_out, alu_carry, alu_half_carry, alu_overflow, op_valid,
           is_adc, is_sbc, upd_nz, upd_c, upd_v, upd_bit, bit_operand,
           p_load, p_in, flag_wr, flag_sel, flag_val,
    output result, result_valid, busy, p_out, c_flag, dec_add
  );
endinterface

// File: rtl/alu_status_stage.sv
// Registers ALU results, applies BCD adjust and maintains the P status register.
// Define CMOS_DECIMAL_EN to perform the decimal adjust in an extra busy cycle.
module alu_status_stage (
  input  logic              clk,
  input  logic              reset,
  alu_status_stage_if.slave bus
);
  localparam int unsigned     DataW  = 8;
  localparam int unsigned     BitN   = 7;
  localparam int unsigned     BitV   = 6;
  localparam int unsigned     BitD   = 3;
  localparam int unsigned     BitZ   = 1;
  localparam int unsigned     BitC   = 0;
  localparam logic [DataW-1:0] PReset = 8'h34;

  typedef enum logic {IDLE = 1'b0, DECADJ = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [DataW-1:0] result_q, result_d;
  logic             result_valid_q, result_valid_d;
  logic             busy_q, busy_d;
  logic [DataW-1:0] p_q, p_d;
  logic [DataW-1:0] p_alu;
  logic             dec_start;

`ifdef CMOS_DECIMAL_EN
  typedef struct packed {
    logic [DataW-1:0] alu_out;
    logic             carry;
    logic             half_carry;
    logic             overflow;
    logic             is_adc;
    logic             is_sbc;
    logic             upd_nz;
    logic             upd_c;
    logic             upd_v;
  } dec_op_t;

  dec_op_t pend_q, pend_d;
`endif

  // Nibble-wise BCD correction driven purely by the ALU carries; no inter-nibble carry.
  function automatic logic [DataW-1:0] dec_adjust(input logic [DataW-1:0] bin,
                                                  input logic adc, input logic sbc,
                                                  input logic hc, input logic c);
    logic [3:0] lo;
    logic [3:0] hi;
    lo = bin[3:0];
    hi = bin[7:4];
    if (adc && hc)        lo = lo + 4'h6;
    else if (sbc && !hc)  lo = lo + 4'hA;
    if (adc && c)         hi = hi + 4'h6;
    else if (sbc && !c)   hi = hi + 4'hA;
    return {hi, lo};
  endfunction

  function automatic logic [DataW-1:0] alu_flags(input logic [DataW-1:0] p,
                                                 input logic [DataW-1:0] nz_basis,
                                                 input logic upd_nz, input logic upd_c,
                                                 input logic carry, input logic upd_v,
                                                 input logic overflow);
    logic [DataW-1:0] r;
    r = p;
    if (upd_nz) begin
      r[BitN] = nz_basis[DataW-1];
      r[BitZ] = (nz_basis == '0);
    end
    if (upd_c) r[BitC] = carry;
    if (upd_v) r[BitV] = overflow;
    return r;
  endfunction

  always_comb begin
    state_d        = state_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    p_alu          = p_q;
    dec_start      = bus.op_valid && p_q[BitD] && (bus.is_adc || bus.is_sbc);
`ifdef CMOS_DECIMAL_EN
    pend_d         = pend_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.op_valid) begin
`ifdef CMOS_DECIMAL_EN
          if (dec_start) begin
            state_d = DECADJ;
            pend_d  = '{alu_out: bus.alu_out, carry: bus.alu_carry,
                        half_carry: bus.alu_half_carry, overflow: bus.alu_overflow,
                        is_adc: bus.is_adc, is_sbc: bus.is_sbc, upd_nz: bus.upd_nz,
                        upd_c: bus.upd_c, upd_v: bus.upd_v};
          end else begin
            result_d       = bus.alu_out;
            result_valid_d = 1'b1;
            p_alu = alu_flags(p_q, bus.alu_out, bus.upd_nz, bus.upd_c, bus.alu_carry,
                              bus.upd_v, bus.alu_overflow);
            if (bus.upd_bit) begin
              p_alu[BitN] = bus.bit_operand[1];
              p_alu[BitV] = bus.bit_operand[0];
              p_alu[BitZ] = (bus.alu_out == '0);
            end
          end
`else
          // N/Z follow the unadjusted binary value in this build
          result_d       = dec_start ? dec_adjust(bus.alu_out, bus.is_adc, bus.is_sbc,
                                                  bus.alu_half_carry, bus.alu_carry)
                                     : bus.alu_out;
          result_valid_d = 1'b1;
          p_alu = alu_flags(p_q, bus.alu_out, bus.upd_nz, bus.upd_c, bus.alu_carry,
                            bus.upd_v, bus.alu_overflow);
          if (bus.upd_bit) begin
            p_alu[BitN] = bus.bit_operand[1];
            p_alu[BitV] = bus.bit_operand[0];
            p_alu[BitZ] = (bus.alu_out == '0);
          end
`endif
        end
      end
      DECADJ: begin
`ifdef CMOS_DECIMAL_EN
        result_d       = dec_adjust(pend_q.alu_out, pend_q.is_adc, pend_q.is_sbc,
                                    pend_q.half_carry, pend_q.carry);
        result_valid_d = 1'b1;
        p_alu = alu_flags(p_q, result_d, pend_q.upd_nz, pend_q.upd_c, pend_q.carry,
                          pend_q.upd_v, pend_q.overflow);
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // flag_wr beats p_load beats the ALU, bit by bit
    p_d = p_alu;
    if (bus.p_load) p_d = {bus.p_in[7:6], 2'b11, bus.p_in[3:0]};
    if (bus.flag_wr && (bus.flag_sel != 3'd4) && (bus.flag_sel != 3'd5)) begin
      p_d[bus.flag_sel] = bus.flag_val;
    end
    p_d[5:4] = 2'b11;

`ifdef CMOS_DECIMAL_EN
    busy_d = (state_d == DECADJ);
`else
    busy_d = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      p_q            <= PReset;
`ifdef CMOS_DECIMAL_EN
      pend_q         <= '0;
`endif
    end else begin
      state_q        <= state_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      busy_q         <= busy_d;
      p_q            <= p_d;
`ifdef CMOS_DECIMAL_EN
      pend_q         <= pend_d;
`endif
    end
  end

  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.busy         = busy_q;
  assign bus.p_out        = p_q;
  assign bus.c_flag       = p_q[BitC];
  assign bus.dec_add      = p_q[BitD] & bus.is_adc;
endmodule

// File: tb/tb_alu_status_stage.sv
// Self-checking bench for alu_status_stage: directed scenarios plus a randomized run
// against a flag-level reference model.
`timescale 1ns/1ps
module tb_alu_status_stage;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  alu_status_stage_if bus_if();

  alu_status_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_if.alu_out        = 8'h00;
    bus_if.alu_carry      = 1'b0;
    bus_if.alu_half_carry = 1'b0;
    bus_if.alu_overflow   = 1'b0;
    bus_if.op_valid       = 1'b0;
    bus_if.is_adc         = 1'b0;
    bus_if.is_sbc         = 1'b0;
    bus_if.upd_nz         = 1'b0;
    bus_if.upd_c          = 1'b0;
    bus_if.upd_v          = 1'b0;
    bus_if.upd_bit        = 1'b0;
    bus_if.bit_operand    = 2'b00;
    bus_if.p_load         = 1'b0;
    bus_if.p_in           = 8'h00;
    bus_if.flag_wr        = 1'b0;
    bus_if.flag_sel       = 3'd0;
    bus_if.flag_val       = 1'b0;
  endtask

  task automatic load_p(input logic [7:0] v);
    bus_if.p_load = 1'b1;
    bus_if.p_in   = v;
    tick();
    bus_if.p_load = 1'b0;
  endtask

  // Reference BCD correction written as nibble arithmetic.
  function automatic logic [7:0] bcd_fix(input logic [7:0] v, input bit adc, input bit sbc,
                                         input bit hc, input bit c);
    int lo;
    int hi;
    lo = int'(v) % 16;
    hi = int'(v) / 16;
    if (adc && hc)  lo += 6;
    if (sbc && !hc) lo += 10;
    if (adc && c)   hi += 6;
    if (sbc && !c)  hi += 10;
    return 8'((hi % 16) * 16 + (lo % 16));
  endfunction

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    #1 reset = 1'b1;
    #2;
    total++; if (bus_if.result !== 8'h00) begin bad++; $display("FAIL reset_result: got %h want 00", bus_if.result); end
    total++; if (bus_if.result_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus_if.result_valid); end
    total++; if (bus_if.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus_if.busy); end
    total++; if (bus_if.p_out !== 8'h34) begin bad++; $display("FAIL reset_p: got %h want 34", bus_if.p_out); end
    total++; if (bus_if.c_flag !== 1'b0) begin bad++; $display("FAIL reset_c_flag: got %b want 0", bus_if.c_flag); end
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_binary();
    bus_if.op_valid = 1'b1;
    bus_if.alu_out  = 8'h80;
    bus_if.upd_nz   = 1'b1;
    tick();
    idle_inputs();
    total++; if (bus_if.result !== 8'h80) begin bad++; $display("FAIL bin_result: got %h want 80", bus_if.result); end
    total++; if (bus_if.result_valid !== 1'b1) begin bad++; $display("FAIL bin_valid: got %b want 1", bus_if.result_valid); end
    total++; if (bus_if.busy !== 1'b0) begin bad++; $display("FAIL bin_busy: got %b want 0", bus_if.busy); end
    total++; if (bus_if.p_out !== 8'hB4) begin bad++; $display("FAIL bin_p: got %h want b4", bus_if.p_out); end
    tick();
    total++; if (bus_if.result_valid !== 1'b0) begin bad++; $display("FAIL bin_valid_drop: got %b want 0", bus_if.result_valid); end
    total++; if (bus_if.busy !== 1'b0) begin bad++; $display("FAIL bin_busy_after: got %b want 0", bus_if.busy); end
  endtask

  task automatic test_decimal_adc();
    load_p(8'h08);
    bus_if.op_valid       = 1'b1;
    bus_if.is_adc         = 1'b1;
    bus_if.alu_out        = 8'h41;
    bus_if.alu_half_carry = 1'b1;
    bus_if.alu_carry      = 1'b0;
    bus_if.upd_nz         = 1'b1;
    bus_if.upd_c          = 1'b1;
    bus_if.upd_v          = 1'b1;
    #1;
    total++; if (bus_if.dec_add !== 1'b1) begin bad++; $display("FAIL adc_dec_add: got %b want 1", bus_if.dec_add); end
    tick();
    idle_inputs();
`ifdef CMOS_DECIMAL_EN
    total++; if (bus_if.busy !== 1'b1) begin bad++; $display("FAIL adc_busy: got %b want 1", bus_if.busy); end
    total++; if (bus_if.result_valid !== 1'b0) begin bad++; $display("FAIL adc_early_valid: got %b want 0", bus_if.result_valid); end
    bus_if.op_valid = 1'b1;
    bus_if.alu_out  = 8'hFF;
    bus_if.upd_nz   = 1'b1;
    tick();
    idle_inputs();
`endif
    total++; if (bus_if.result !== 8'h47) begin bad++; $display("FAIL adc_result: got %h want 47", bus_if.result); end
    total++; if (bus_if.result_valid !== 1'b1) begin bad++; $display("FAIL adc_valid: got %b want 1", bus_if.result_valid); end
    total++; if (bus_if.busy !== 1'b0) begin bad++; $display("FAIL adc_busy_done: got %b want 0", bus_if.busy); end
    total++; if (bus_if.p_out !== 8'h38) begin bad++; $display("FAIL adc_p: got %h want 38", bus_if.p_out); end
`ifdef CMOS_DECIMAL_EN
    tick();
    total++; if (bus_if.result_valid !== 1'b0) begin bad++; $display("FAIL adc_ignored_op_valid: got %b want 0", bus_if.result_valid); end
    total++; if (bus_if.result !== 8'h47) begin bad++; $display("FAIL adc_ignored_op_result: got %h want 47", bus_if.result); end
`endif
  endtask

  task automatic test_decimal_sbc();
    load_p(8'h08);
    bus_if.op_valid       = 1'b1;
    bus_if.is_sbc         = 1'b1;
    bus_if.alu_out        = 8'h0F;
    bus_if.alu_half_carry = 1'b0;
    bus_if.alu_carry      = 1'b1;
    bus_if.upd_nz         = 1'b1;
    bus_if.upd_c          = 1'b1;
    #1;
    total++; if (bus_if.dec_add !== 1'b0) begin bad++; $display("FAIL sbc_dec_add: got %b want 0", bus_if.dec_add); end
    tick();
    idle_inputs();
`ifdef CMOS_DECIMAL_EN
    total++; if (bus_if.busy !== 1'b1) begin bad++; $display("FAIL sbc_busy: got %b want 1", bus_if.busy); end
    tick();
`endif
    total++; if (bus_if.result !== 8'h09) begin bad++; $display("FAIL sbc_result: got %h want 09", bus_if.result); end
    total++; if (bus_if.result_valid !== 1'b1) begin bad++; $display("FAIL sbc_valid: got %b want 1", bus_if.result_valid); end
    total++; if (bus_if.p_out !== 8'h39) begin bad++; $display("FAIL sbc_p: got %h want 39", bus_if.p_out); end
    total++; if (bus_if.c_flag !== 1'b1) begin bad++; $display("FAIL sbc_c_flag: got %b want 1", bus_if.c_flag); end
  endtask

  task automatic test_priority();
    bus_if.p_load   = 1'b1;
    bus_if.p_in     = 8'h00;
    bus_if.flag_wr  = 1'b1;
    bus_if.flag_sel = 3'd0;
    bus_if.flag_val = 1'b1;
    tick();
    idle_inputs();
    total++; if (bus_if.p_out !== 8'h31) begin bad++; $display("FAIL prio_load_vs_wr: got %h want 31", bus_if.p_out); end
    for (int s = 4; s <= 5; s++) begin
      bus_if.flag_wr  = 1'b1;
      bus_if.flag_sel = 3'(s);
      bus_if.flag_val = 1'b0;
      tick();
      idle_inputs();
      total++; if (bus_if.p_out !== 8'h31) begin bad++; $display("FAIL prio_sel%0d_noop: got %h want 31", s, bus_if.p_out); end
    end
    bus_if.op_valid = 1'b1;
    bus_if.alu_out  = 8'h00;
    bus_if.upd_nz   = 1'b1;
    bus_if.upd_c    = 1'b1;
    bus_if.flag_wr  = 1'b1;
    bus_if.flag_sel = 3'd1;
    bus_if.flag_val = 1'b0;
    tick();
    idle_inputs();
    total++; if (bus_if.p_out !== 8'h30) begin bad++; $display("FAIL prio_wr_vs_alu: got %h want 30", bus_if.p_out); end
    bus_if.op_valid = 1'b1;
    bus_if.alu_out  = 8'h80;
    bus_if.upd_nz   = 1'b1;
    bus_if.p_load   = 1'b1;
    bus_if.p_in     = 8'h02;
    tick();
    idle_inputs();
    total++; if (bus_if.p_out !== 8'h32) begin bad++; $display("FAIL prio_load_vs_alu: got %h want 32", bus_if.p_out); end
  endtask

  task automatic test_bit();
    load_p(8'h01);
    bus_if.op_valid    = 1'b1;
    bus_if.upd_bit     = 1'b1;
    bus_if.bit_operand = 2'b11;
    bus_if.alu_out     = 8'h00;
    tick();
    idle_inputs();
    total++; if (bus_if.p_out !== 8'hF3) begin bad++; $display("FAIL bit_p: got %h want f3", bus_if.p_out); end
    total++; if (bus_if.c_flag !== 1'b1) begin bad++; $display("FAIL bit_c_kept: got %b want 1", bus_if.c_flag); end
    total++; if (bus_if.result_valid !== 1'b1) begin bad++; $display("FAIL bit_valid: got %b want 1", bus_if.result_valid); end
  endtask

  task automatic test_reset_mid_decadj();
    load_p(8'h08);
    bus_if.op_valid       = 1'b1;
    bus_if.is_adc         = 1'b1;
    bus_if.alu_out        = 8'h41;
    bus_if.alu_half_carry = 1'b1;
    bus_if.upd_nz         = 1'b1;
    tick();
    idle_inputs();
`ifdef CMOS_DECIMAL_EN
    total++; if (bus_if.busy !== 1'b1) begin bad++; $display("FAIL rst_mid_busy_before: got %b want 1", bus_if.busy); end
`endif
    #2 reset = 1'b1;
    #1;
    total++; if (bus_if.p_out !== 8'h34) begin bad++; $display("FAIL rst_mid_p: got %h want 34", bus_if.p_out); end
    total++; if (bus_if.result !== 8'h00) begin bad++; $display("FAIL rst_mid_result: got %h want 00", bus_if.result); end
    total++; if (bus_if.result_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid: got %b want 0", bus_if.result_valid); end
    total++; if (bus_if.busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy: got %b want 0", bus_if.busy); end
    tick();
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      total++; if (bus_if.result_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_no_pulse%0d: got %b want 0", k, bus_if.result_valid); end
    end
    bus_if.op_valid = 1'b1;
    bus_if.alu_out  = 8'h5A;
    tick();
    idle_inputs();
    total++; if (bus_if.result !== 8'h5A || bus_if.result_valid !== 1'b1) begin
      bad++; $display("FAIL rst_mid_idle_op: got %h/%b want 5a/1", bus_if.result, bus_if.result_valid);
    end
  endtask

  task automatic test_random(input int n);
    bit mN, mV, mD, mI, mZ, mC, nN, nV, nD, nI, nZ, nC;
    logic [7:0] mres, nres, nzb, exp_p;
    bit mval, nval, mbusy, nbusy;
    bit do_nz, do_c, do_v, cv, vv, do_bit, dec;
    int kind;
`ifdef CMOS_DECIMAL_EN
    bit pend, npend;
    logic [7:0] pv;
    bit p_c, p_hc, p_v, p_adc, p_sbc, p_unz, p_uc, p_uv;
    pend = 1'b0;
`endif
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    {mN, mV, mD, mI, mZ, mC} = 6'b000100;
    mres = 8'h00; mval = 1'b0; mbusy = 1'b0;
    for (int k = 0; k < n; k++) begin
      kind = int'($urandom_range(0, 3));
      bus_if.op_valid       = ($urandom_range(0, 2) != 0);
      bus_if.alu_out        = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      bus_if.alu_carry      = 1'($urandom);
      bus_if.alu_half_carry = 1'($urandom);
      bus_if.alu_overflow   = 1'($urandom);
      bus_if.is_adc         = (kind == 0);
      bus_if.is_sbc         = (kind == 1);
      bus_if.upd_bit        = (kind == 3);
      bus_if.upd_nz         = (kind != 3) && ($urandom_range(0, 1) == 1);
      bus_if.upd_v          = (kind != 3) && ($urandom_range(0, 1) == 1);
      bus_if.upd_c          = 1'($urandom);
      bus_if.bit_operand    = 2'($urandom);
      bus_if.p_load         = ($urandom_range(0, 9) == 0);
      bus_if.p_in           = 8'($urandom);
      bus_if.flag_wr        = ($urandom_range(0, 3) == 0);
      bus_if.flag_sel       = 3'($urandom);
      bus_if.flag_val       = 1'($urandom);
      #1;
      total++; if (bus_if.dec_add !== (mD & bus_if.is_adc)) begin
        bad++; $display("FAIL rnd_dec_add @%0d: got %b want %b", k, bus_if.dec_add, mD & bus_if.is_adc);
      end

      {nN, nV, nD, nI, nZ, nC} = {mN, mV, mD, mI, mZ, mC};
      nres = mres; nval = 1'b0; nbusy = 1'b0;
      do_nz = 1'b0; do_c = 1'b0; do_v = 1'b0; do_bit = 1'b0;
      nzb = 8'h00; cv = 1'b0; vv = 1'b0;
      dec = mD && (bus_if.is_adc || bus_if.is_sbc);
`ifdef CMOS_DECIMAL_EN
      npend = 1'b0;
      if (pend) begin
        nres = bcd_fix(pv, p_adc, p_sbc, p_hc, p_c);
        nval = 1'b1;
        nzb = nres; do_nz = p_unz; do_c = p_uc; cv = p_c; do_v = p_uv; vv = p_v;
      end else if (bus_if.op_valid && dec) begin
        npend = 1'b1;
        nbusy = 1'b1;
        pv = bus_if.alu_out; p_c = bus_if.alu_carry; p_hc = bus_if.alu_half_carry;
        p_v = bus_if.alu_overflow; p_adc = bus_if.is_adc; p_sbc = bus_if.is_sbc;
        p_unz = bus_if.upd_nz; p_uc = bus_if.upd_c; p_uv = bus_if.upd_v;
      end else
`endif
      if (bus_if.op_valid) begin
        nres = dec ? bcd_fix(bus_if.alu_out, bus_if.is_adc, bus_if.is_sbc,
                             bus_if.alu_half_carry, bus_if.alu_carry) : bus_if.alu_out;
        nval = 1'b1;
        nzb = bus_if.alu_out; do_nz = bus_if.upd_nz; do_c = bus_if.upd_c; cv = bus_if.alu_carry;
        do_v = bus_if.upd_v; vv = bus_if.alu_overflow; do_bit = bus_if.upd_bit;
      end
      if (do_nz) begin nN = nzb[7]; nZ = (nzb == 8'h00); end
      if (do_c) nC = cv;
      if (do_v) nV = vv;
      if (do_bit) begin nN = bus_if.bit_operand[1]; nV = bus_if.bit_operand[0]; nZ = (bus_if.alu_out == 8'h00); end
      if (bus_if.p_load) {nN, nV, nD, nI, nZ, nC} = {bus_if.p_in[7:6], bus_if.p_in[3:0]};
      if (bus_if.flag_wr) begin
        case (bus_if.flag_sel)
          3'd7: nN = bus_if.flag_val;
          3'd6: nV = bus_if.flag_val;
          3'd3: nD = bus_if.flag_val;
          3'd2: nI = bus_if.flag_val;
          3'd1: nZ = bus_if.flag_val;
          3'd0: nC = bus_if.flag_val;
          default: ;
        endcase
      end
      exp_p = {nN, nV, 2'b11, nD, nI, nZ, nC};

      tick();
      total++; if (bus_if.result !== nres) begin bad++; $display("FAIL rnd_result @%0d: got %h want %h", k, bus_if.result, nres); end
      total++; if (bus_if.result_valid !== nval) begin bad++; $display("FAIL rnd_valid @%0d: got %b want %b", k, bus_if.result_valid, nval); end
      total++; if (bus_if.busy !== nbusy) begin bad++; $display("FAIL rnd_busy @%0d: got %b want %b", k, bus_if.busy, nbusy); end
      total++; if (bus_if.p_out !== exp_p) begin bad++; $display("FAIL rnd_p @%0d: got %h want %h", k, bus_if.p_out, exp_p); end
      total++; if (bus_if.c_flag !== nC) begin bad++; $display("FAIL rnd_c_flag @%0d: got %b want %b", k, bus_if.c_flag, nC); end

      {mN, mV, mD, mI, mZ, mC} = {nN, nV, nD, nI, nZ, nC};
      mres = nres; mval = nval; mbusy = nbusy;
`ifdef CMOS_DECIMAL_EN
      pend = npend;
`endif
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_binary();
    test_decimal_adc();
    test_decimal_sbc();
    test_priority();
    test_bit();
    test_reset_mid_decadj();
    test_random(800);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
